flash_read_arbiter: RTL and testbench
=====================================

# flash_read_arbiter

Shares the single parallel NOR flash read port between two requesters: port A, the note sequencer fetching tone/duration words, and port B, a secondary reader such as a lyric/display fetcher. Each access runs a fixed wait-state read cycle on the flash pins. Each granted read returns the 16-bit word with a one-cycle ACK pulse. The block sits between the requesters and the flash/RAM pins and is the only driver of the flash address and control lines.

## Interface
- WAIT_CYCLES, default 11: flash read access time in CLK cycles (110 ns at 100 MHz); legal range 2..255.
- CLK  in  1  100 MHz system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ_A  in  1  port A read request, level; held high until ACK_A.
- ADDR_A  in  23  port A word address [23:1]; stable while REQ_A high.
- ACK_A  out  1  one-cycle pulse; RDATA_A valid in this cycle.
- RDATA_A  out  16  last word read for port A; held until the next ACK_A.
- REQ_B, ADDR_B, ACK_B, RDATA_B: same as port A, for port B.
- BUSY  out  1  high in any state other than IDLE.
- DATA  in  16  flash data bus.
- ADDR  out  23  flash address [23:1], registered.
- CE  out  1  flash chip enable, active low.
- OE  out  1  flash output enable, active low.
- WE  out  1  flash write enable, constant 1.
- RP  out  1  flash reset/power-down, constant 1.
- MTCE  out  1  RAM chip enable, constant 1 (RAM kept deselected).

## Operation
- States: IDLE, ACCESS, RECOVER. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port not granted last. The round-robin pointer resets so that A wins the first tie.
  - On grant: latch the winner's address into ADDR and record the winner. Go to ACCESS with wait counter = 0, CE=0, OE=0.
- ACCESS:
  - CE=0, OE=0, ADDR held. The counter increments each cycle.
  - In the cycle where counter == WAIT_CYCLES-1: at the closing edge, capture DATA into the winner's RDATA, set the winner's ACK, update the pointer, and go to RECOVER.
- RECOVER:
  - CE=1, OE=1; the winner's ACK is high for this cycle only. Then go to IDLE.
  - Guarantees at least one deselected cycle between back-to-back reads.
- The counter is 8 bits wide and is cleared on entry to ACCESS. It never wraps within an access.
- REQ and ADDR are sampled only in IDLE. Changes during ACCESS/RECOVER are ignored.
- REQ dropped mid-access: the access completes; RDATA is updated and ACK still pulses.
- A requester must deassert REQ at the edge ending its ACK cycle. REQ still high in the following IDLE cycle is a new request.
- The non-winning port's ACK and RDATA are untouched by an access.

## Timing
- Reset values: ACK_A=ACK_B=0, RDATA_A=RDATA_B=16'h0000, ADDR=0, CE=1, OE=1, BUSY=0, pointer=B-last. WE=RP=MTCE=1 always.
- RST high in any state: all of the above at the next edge. Any access in progress is abandoned and no ACK is issued.
- Latency: REQ sampled high in IDLE at cycle 0 → CE/OE low and ADDR valid from cycle 1 through cycle WAIT_CYCLES. ACK and RDATA valid in cycle WAIT_CYCLES+1.
- Throughput: one read per WAIT_CYCLES+2 cycles. With both ports continuously requesting, grants alternate A, B, A, ...
- DATA is sampled at the end of the WAIT_CYCLES-th cycle with OE low.

## Test plan
- Reset: assert RST for 3 cycles → CE=OE=1, ACK_A=ACK_B=0, RDATA_A=RDATA_B=0, BUSY=0, ADDR=0.
- Single read (WAIT_CYCLES=11): REQ_A with ADDR_A=23'h000005, flash model returns 16'h0046 → ADDR=5 with CE=OE=0 for exactly 11 cycles, ACK_A one cycle 12 cycles after the request is sampled, RDATA_A=16'h0046, ACK_B never asserted.
- Tie and round robin: REQ_A and REQ_B both held high for 4 transactions → grant order A, B, A, B, each separated by one RECOVER cycle with CE=1.
- Mid-access change: during an A access, change ADDR_A and drop REQ_A → ADDR unchanged, ACK_A still pulses, RDATA_A holds the original word.
- Reset mid-access: RST pulsed at ACCESS counter=5 → CE=OE=1 next cycle, no ACK, state IDLE; a subsequent tie grants A.
- Back-to-back same port: REQ_A reasserted in the cycle after ACK_A with B idle → second access starts one cycle later, reading ADDR_A's new value.

Source files
------------

// File: rtl/flash_read_arbiter.sv
// Two-port round-robin arbiter for a single NOR flash read port.
// Ports: CLK/RST; REQ/ADDR/ACK/RDATA per requester; BUSY; flash pins.
module flash_read_arbiter #(
  parameter int WAIT_CYCLES = 11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_A,
  input  logic [22:0] ADDR_A,
  output logic        ACK_A,
  output logic [15:0] RDATA_A,
  input  logic        REQ_B,
  input  logic [22:0] ADDR_B,
  output logic        ACK_B,
  output logic [15:0] RDATA_B,
  output logic        BUSY,
  input  logic [15:0] DATA,
  output logic [22:0] ADDR,
  output logic        CE,
  output logic        OE,
  output logic        WE,
  output logic        RP,
  output logic        MTCE
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_t;

  localparam logic [7:0] LAST = 8'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic       win_b;
  logic       last_b;
  logic       grant;
  logic       grant_b;
  logic       done;

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_b  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          grant    = 1'b1;
          // on a tie, B only wins if A was granted last
          grant_b  = REQ_B && (!REQ_A || !last_b);
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == LAST) begin
          done     = 1'b1;
          state_nx = RECOVER;
        end
      end
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      win_b   <= 1'b0;
      last_b  <= 1'b1;
      ADDR    <= 23'd0;
      ACK_A   <= 1'b0;
      ACK_B   <= 1'b0;
      RDATA_A <= 16'h0000;
      RDATA_B <= 16'h0000;
    end else begin
      state <= state_nx;
      ACK_A <= done && !win_b;
      ACK_B <= done && win_b;
      if (grant) begin
        ADDR  <= grant_b ? ADDR_B : ADDR_A;
        win_b <= grant_b;
        cnt   <= 8'd0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 8'd1;
      end
      if (done) begin
        last_b <= win_b;
        if (win_b) RDATA_B <= DATA;
        else       RDATA_A <= DATA;
      end
    end
  end

  // flash is selected only while an access is running
  assign CE   = (state != ACCESS);
  assign OE   = (state != ACCESS);
  assign BUSY = (state != IDLE);
  assign WE   = 1'b1;
  assign RP   = 1'b1;
  assign MTCE = 1'b1;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed testbench for flash_read_arbiter.
// Flash model returns ADDR*14 while selected, 16'hDEAD otherwise.
module tb_flash_read_arbiter;

  localparam int W = 11;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_A = 1'b0;
  logic [22:0] ADDR_A = '0;
  logic        ACK_A;
  logic [15:0] RDATA_A;
  logic        REQ_B = 1'b0;
  logic [22:0] ADDR_B = '0;
  logic        ACK_B;
  logic [15:0] RDATA_B;
  logic        BUSY;
  logic [15:0] DATA;
  logic [22:0] ADDR;
  logic        CE;
  logic        OE;
  logic        WE;
  logic        RP;
  logic        MTCE;

  int nvec = 0;
  int nerr = 0;

  flash_read_arbiter #(.WAIT_CYCLES(W)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .ADDR_A(ADDR_A),
    .ACK_A(ACK_A), .RDATA_A(RDATA_A),
    .REQ_B(REQ_B), .ADDR_B(ADDR_B),
    .ACK_B(ACK_B), .RDATA_B(RDATA_B),
    .BUSY(BUSY), .DATA(DATA), .ADDR(ADDR),
    .CE(CE), .OE(OE), .WE(WE),
    .RP(RP), .MTCE(MTCE)
  );

  always #5 CLK = ~CLK;

  assign DATA = (!CE && !OE)
              ? 16'(ADDR[15:0] * 16'd14)
              : 16'hDEAD;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Call in the IDLE cycle where the request
  // is sampled; returns in the ACK cycle.
  task automatic xact(
    input string       tag,
    input logic        exp_b,
    input logic [22:0] exp_addr,
    input logic [15:0] exp_data,
    input logic [15:0] exp_other,
    input int          chg_at
  );
    int lo = 0;
    int lat = 0;
    logic bad = 1'b0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick();
      if (!CE) begin
        lo++;
        if (ADDR !== exp_addr || OE !== 1'b0)
          bad = 1'b1;
      end
      if (ACK_A || ACK_B) lat = i;
      if (i == chg_at) begin
        ADDR_A = 23'h1FF;
        REQ_A  = 1'b0;
      end
    end
    chk({tag, ".lat"}, lat, W + 1);
    chk({tag, ".celo"}, lo, W);
    chk({tag, ".addr"}, 32'(bad), 0);
    chk({tag, ".ce_rec"}, 32'(CE), 1);
    chk({tag, ".port"}, {ACK_B, ACK_A},
        exp_b ? 2 : 1);
    chk({tag, ".rdata"},
        exp_b ? RDATA_B : RDATA_A, exp_data);
    chk({tag, ".other"},
        exp_b ? RDATA_A : RDATA_B, exp_other);
  endtask

  initial begin
    int acks;

    // reset
    repeat (3) tick();
    chk("rst.ce", CE, 1);
    chk("rst.oe", OE, 1);
    chk("rst.ack", {ACK_A, ACK_B}, 0);
    chk("rst.rda", RDATA_A, 0);
    chk("rst.rdb", RDATA_B, 0);
    chk("rst.busy", BUSY, 0);
    chk("rst.addr", ADDR, 0);
    chk("rst.const", {WE, RP, MTCE}, 3'b111);
    RST = 1'b0;
    tick();

    // single read of address 5
    REQ_A  = 1'b1;
    ADDR_A = 23'h000005;
    xact("single", 1'b0, 23'h5,
         16'h0046, 16'h0000, 0);
    REQ_A  = 1'b0;
    ADDR_A = 23'h000007;

    // back-to-back from A one cycle later
    tick();
    chk("b2b.ack1", {ACK_A, ACK_B}, 0);
    chk("b2b.idle", BUSY, 0);
    REQ_A = 1'b1;
    xact("b2b", 1'b0, 23'h7,
         16'h0062, 16'h0000, 0);
    REQ_A = 1'b0;

    // ADDR_A / REQ_A change mid-access
    tick();
    REQ_A  = 1'b1;
    ADDR_A = 23'h000100;
    xact("mid", 1'b0, 23'h100,
         16'h0E00, 16'h0000, 3);
    tick();
    chk("mid.ack1", {ACK_A, ACK_B}, 0);

    // reset while counter is 5
    REQ_A  = 1'b1;
    ADDR_A = 23'h000003;
    repeat (6) tick();
    chk("rma.ce", CE, 0);
    RST   = 1'b1;
    REQ_A = 1'b0;
    tick();
    chk("rma.ce1", CE, 1);
    chk("rma.oe1", OE, 1);
    chk("rma.busy", BUSY, 0);
    chk("rma.rda", RDATA_A, 0);
    RST  = 1'b0;
    acks = 0;
    repeat (16) begin
      tick();
      if (ACK_A || ACK_B) acks++;
    end
    chk("rma.noack", acks, 0);

    // tie, round robin A B A B
    REQ_A  = 1'b1;
    REQ_B  = 1'b1;
    ADDR_A = 23'h000010;
    ADDR_B = 23'h000020;
    xact("rr0", 1'b0, 23'h10,
         16'h00E0, 16'h0000, 0);
    tick();
    chk("rr0.idle", BUSY, 0);
    xact("rr1", 1'b1, 23'h20,
         16'h01C0, 16'h00E0, 0);
    tick();
    chk("rr1.idle", BUSY, 0);
    xact("rr2", 1'b0, 23'h10,
         16'h00E0, 16'h01C0, 0);
    tick();
    chk("rr2.idle", BUSY, 0);
    xact("rr3", 1'b1, 23'h20,
         16'h01C0, 16'h00E0, 0);
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    tick();
    chk("end.ack1", {ACK_A, ACK_B}, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
